argo_fifo: RTL and testbench
============================

Name: argo_fifo

Overview:
Synchronous single-clock FIFO used as the channel primitive between Argo-generated control/data-flow state machines. A writer process pushes words with wr_en, gated by full. A reader process pops words with rd_en, gated by empty. Read data is registered and appears one cycle after the accepted read. Each instance carries a FIFO_ID tag for debug identification.

Parameters:
ADDR_WIDTH, 4, pointer width in bits.
DATA_WIDTH, 32, word width in bits.
DEPTH, 16, storage entries; must satisfy 2 <= DEPTH <= 2**ADDR_WIDTH (normally 1<<ADDR_WIDTH).
FIFO_ID, 0, integer tag; used only by the debug feature, no functional effect.

Ports:
clk  input  1  clock; all logic on rising edge.
rst  input  1  synchronous, active-high reset.
rd_en  input  1  pop request.
rd_data  output  DATA_WIDTH  registered read data.
wr_en  input  1  push request.
wr_data  input  DATA_WIDTH  write data.
full  output  1  high when count == DEPTH.
empty  output  1  high when count == 0.

Behaviour:
- Reset is synchronous and active-high. With rst=1 at a rising edge: write pointer, read pointer and count go to 0, and rd_data goes to 0. The storage array is not cleared. After reset, empty=1 and full=0. rst has priority over rd_en and wr_en in that cycle.
- Reset mid-operation discards all stored words. The FIFO behaves as empty from the next cycle.
- Internal state:
  - wr_ptr and rd_ptr, each ADDR_WIDTH bits.
  - count, ADDR_WIDTH+1 bits, range 0..DEPTH.
- Pointers advance by 1 and wrap from DEPTH-1 to 0. This must work for non-power-of-2 DEPTH.
- Write acceptance: when wr_en=1 and full=0, wr_data is stored at mem[wr_ptr] and wr_ptr increments.
- Write rejection: wr_en while full is ignored. No state changes and no data is overwritten.
- Read acceptance: when rd_en=1 and empty=0, rd_data <= mem[rd_ptr] at that edge and rd_ptr increments. Latency is 1 cycle: data is valid the cycle after the accepting edge.
- rd_data holding: rd_data keeps its last value until the next accepted read.
- Read rejection: rd_en while empty is ignored. rd_data, pointers and count are unchanged.
- Count update:
  - +1 on an accepted write only.
  - -1 on an accepted read only.
  - Unchanged when both are accepted in the same cycle.
- full and empty are combinational decodes of the registered count, so they are valid the cycle after the change.
- Simultaneous rd_en and wr_en:
  - Not empty and not full: both are accepted, count is unchanged.
  - Empty: the write is accepted and the read is ignored. The new word is readable from the next cycle; no write-through bypass.
  - Full: the read is accepted and the write is ignored. Producers retry on !full.
- Ordering is strictly first-in first-out. No data is lost or duplicated across pointer wrap.
- rd_data must not change on any edge without an accepted read.

Optional Feature:
ARGO_FIFO_DEBUG_EN
- Defined: adds simulation-only $display messages, each tagged with FIFO_ID and the value of an internal free-running cycle counter.
  - On every accepted write: data and wr_ptr.
  - On every accepted read: data and rd_ptr.
  - On write-while-full: "overflow attempt".
  - On read-while-empty: "underflow attempt".
- Defined: adds sticky internal regs ovf_seen and unf_seen, cleared by rst. These are not ports.
- Undefined: none of this logic exists. Functional behaviour is identical in both builds.

Test Plan:
- Reset (DEPTH=16, DW=32): hold rst=1 for 2 cycles, release -> empty=1, full=0, rd_data=0; a rd_en pulse leaves rd_data=0 and empty=1.
- Single word: write 0x00000005 -> empty=0 next cycle; pulse rd_en -> rd_data=5 one cycle later, empty=1, and rd_data stays 5 for the next 3 idle cycles.
- Fill to full: write 1..16 -> full=1 after the 16th write. Write 0xDEAD while full -> ignored. Read 16 words -> exactly 1..16 in order, then empty=1.
- Wrap with ADDR_WIDTH=3, DEPTH=8: stream 20 words 0..19, interleaving 3 writes per 2 reads and draining at the end -> read sequence is 0..19 with no gaps or duplicates.
- Simultaneous ops:
  - Empty + rd_en + wr_en(7): empty=0, count=1, rd_data unchanged.
  - Half-full (4 words) + rd_en + wr_en: count stays 4, head word read.
  - Full + both: one word read, write dropped, full=0.
- Mid-operation reset: write 3 words, assert rst for 1 cycle -> empty=1. Then write 0x42 and read -> rd_data=0x42.

Source files
------------

// File: rtl/argo_fifo.sv
// argo_fifo: single-clock FIFO channel with registered read data and a 1-cycle read latency.
// Define ARGO_FIFO_DEBUG_EN to add simulation traces tagged with FIFO_ID and sticky overflow/underflow flags.
module argo_fifo #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int FIFO_ID    = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  full,
    output logic                  empty
);
    localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   CNT_FULL = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH + 1)'(1);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic                  w_wr_acc;
    logic                  w_rd_acc;

    assign full     = r_count == CNT_FULL;
    assign empty    = r_count == '0;
    assign w_wr_acc = wr_en && !full;
    assign w_rd_acc = rd_en && !empty;

    // Storage is never cleared; reset only forgets it through the pointers.
    always_ff @(posedge clk) begin
        if (!rst && w_wr_acc)
            r_mem[r_wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            rd_data  <= '0;
        end else begin
            if (w_wr_acc)
                r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + PTR_ONE;
            if (w_rd_acc) begin
                r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + PTR_ONE;
                rd_data  <= r_mem[r_rd_ptr];
            end
            r_count <= (w_wr_acc && !w_rd_acc) ? r_count + CNT_ONE :
                       (w_rd_acc && !w_wr_acc) ? r_count - CNT_ONE : r_count;
        end
    end

`ifdef ARGO_FIFO_DEBUG_EN
    logic [31:0] r_cycle;
    logic        r_ovf_seen;
    logic        r_unf_seen;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cycle    <= '0;
            r_ovf_seen <= 1'b0;
            r_unf_seen <= 1'b0;
        end else begin
            r_cycle <= r_cycle + 32'd1;
            if (wr_en && full)
                r_ovf_seen <= 1'b1;
            if (rd_en && empty)
                r_unf_seen <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (w_wr_acc)
                $display("[argo_fifo %0d @%0d] write data=%h wr_ptr=%0d", FIFO_ID, r_cycle, wr_data, r_wr_ptr);
            if (w_rd_acc)
                $display("[argo_fifo %0d @%0d] read data=%h rd_ptr=%0d", FIFO_ID, r_cycle, r_mem[r_rd_ptr], r_rd_ptr);
            if (wr_en && full)
                $display("[argo_fifo %0d @%0d] overflow attempt", FIFO_ID, r_cycle);
            if (rd_en && empty)
                $display("[argo_fifo %0d @%0d] underflow attempt", FIFO_ID, r_cycle);
        end
    end
`endif
endmodule

// File: tb/tb_argo_fifo.sv
// tb_argo_fifo: directed checks of argo_fifo at DEPTH=16 and a DEPTH=8 instance for pointer wrap.
module tb_argo_fifo;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rd_en = 1'b0;
    logic        wr_en = 1'b0;
    logic [31:0] wr_data = '0;
    logic [31:0] rd_data;
    logic        full;
    logic        empty;
    logic        rd8 = 1'b0;
    logic        wr8 = 1'b0;
    logic [31:0] wd8 = '0;
    logic [31:0] rd_data8;
    logic        full8;
    logic        empty8;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    argo_fifo #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .DEPTH(16), .FIFO_ID(1)) u_dut (
        .clk(clk), .rst(rst), .rd_en(rd_en), .rd_data(rd_data),
        .wr_en(wr_en), .wr_data(wr_data), .full(full), .empty(empty)
    );

    argo_fifo #(.ADDR_WIDTH(3), .DATA_WIDTH(32), .DEPTH(8), .FIFO_ID(2)) u_dut8 (
        .clk(clk), .rst(rst), .rd_en(rd8), .rd_data(rd_data8),
        .wr_en(wr8), .wr_data(wd8), .full(full8), .empty(empty8)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL reset_empty: got %b want 1", empty); end
        n_cmp++; if (full !== 1'b0) begin n_err++; $display("FAIL reset_full: got %b want 0", full); end
        n_cmp++; if (rd_data !== 32'h0) begin n_err++; $display("FAIL reset_rd_data: got %h want 0", rd_data); end
        n_cmp++; if (empty8 !== 1'b1) begin n_err++; $display("FAIL reset_empty8: got %b want 1", empty8); end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        n_cmp++; if (rd_data !== 32'h0) begin n_err++; $display("FAIL underflow_rd_data: got %h want 0", rd_data); end
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL underflow_empty: got %b want 1", empty); end
    endtask

    task automatic test_single();
        wr_en = 1'b1; wr_data = 32'h5;
        tick();
        wr_en = 1'b0;
        n_cmp++; if (empty !== 1'b0) begin n_err++; $display("FAIL single_not_empty: got %b want 0", empty); end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        n_cmp++; if (rd_data !== 32'h5) begin n_err++; $display("FAIL single_rd_data: got %h want 5", rd_data); end
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL single_empty: got %b want 1", empty); end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (rd_data !== 32'h5) begin n_err++; $display("FAIL single_hold%0d: got %h want 5", i, rd_data); end
        end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 16; i++) begin
            wr_en = 1'b1; wr_data = i;
            tick();
            if (i == 15) begin
                n_cmp++; if (full !== 1'b0) begin n_err++; $display("FAIL fill_full_at15: got %b want 0", full); end
            end
        end
        n_cmp++; if (full !== 1'b1) begin n_err++; $display("FAIL fill_full: got %b want 1", full); end
        wr_data = 32'hDEAD;
        tick();
        wr_en = 1'b0;
        n_cmp++; if (full !== 1'b1) begin n_err++; $display("FAIL fill_ovf_full: got %b want 1", full); end
        rd_en = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            n_cmp++; if (rd_data !== 32'(i)) begin n_err++; $display("FAIL fill_read%0d: got %h want %h", i, rd_data, 32'(i)); end
            if (i == 1) begin
                n_cmp++; if (full !== 1'b0) begin n_err++; $display("FAIL fill_unfull: got %b want 0", full); end
            end
        end
        rd_en = 1'b0;
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL fill_drained: got %b want 1", empty); end
        tick();
        n_cmp++; if (rd_data !== 32'd16) begin n_err++; $display("FAIL fill_hold: got %h want 10", rd_data); end
    endtask

    task automatic test_wrap();
        int nw = 0;
        int nr = 0;
        int cnt = 0;
        int c = 0;
        bit do_wr;
        bit do_rd;
        while (nr < 20 && c < 200) begin
            do_wr = (c % 5 < 3) && nw < 20 && cnt < 8;
            do_rd = ((c % 5 >= 3) || nw == 20) && cnt > 0;
            wr8 = do_wr; wd8 = nw; rd8 = do_rd;
            tick();
            if (do_wr) nw++;
            if (do_rd) begin
                n_cmp++; if (rd_data8 !== 32'(nr)) begin n_err++; $display("FAIL wrap_read%0d: got %h want %h", nr, rd_data8, 32'(nr)); end
                nr++;
            end
            cnt += int'(do_wr) - int'(do_rd);
            c++;
        end
        wr8 = 1'b0; rd8 = 1'b0;
        n_cmp++; if (nr !== 20) begin n_err++; $display("FAIL wrap_timeout: got %0d reads want 20", nr); end
        n_cmp++; if (empty8 !== 1'b1) begin n_err++; $display("FAIL wrap_empty: got %b want 1", empty8); end
    endtask

    task automatic test_simul();
        rd_en = 1'b1; wr_en = 1'b1; wr_data = 32'h7;
        tick();
        rd_en = 1'b0; wr_en = 1'b0;
        n_cmp++; if (empty !== 1'b0) begin n_err++; $display("FAIL simul_empty_accept: got %b want 0", empty); end
        n_cmp++; if (rd_data !== 32'd16) begin n_err++; $display("FAIL simul_empty_rd_hold: got %h want 10", rd_data); end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        n_cmp++; if (rd_data !== 32'h7) begin n_err++; $display("FAIL simul_empty_word: got %h want 7", rd_data); end
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL simul_empty_count1: got %b want 1", empty); end
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1; wr_data = 32'h10 + i;
            tick();
        end
        rd_en = 1'b1; wr_data = 32'h14;
        tick();
        wr_en = 1'b0;
        n_cmp++; if (rd_data !== 32'h10) begin n_err++; $display("FAIL simul_half_head: got %h want 10", rd_data); end
        for (int i = 1; i <= 4; i++) begin
            tick();
            n_cmp++; if (rd_data !== 32'h10 + i) begin n_err++; $display("FAIL simul_half_read%0d: got %h want %h", i, rd_data, 32'h10 + i); end
            if (i == 3) begin
                n_cmp++; if (empty !== 1'b0) begin n_err++; $display("FAIL simul_half_count: got %b want 0", empty); end
            end
        end
        rd_en = 1'b0;
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL simul_half_drained: got %b want 1", empty); end
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; wr_data = 32'h100 + i;
            tick();
        end
        n_cmp++; if (full !== 1'b1) begin n_err++; $display("FAIL simul_full_pre: got %b want 1", full); end
        rd_en = 1'b1; wr_data = 32'hBEEF;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        n_cmp++; if (rd_data !== 32'h100) begin n_err++; $display("FAIL simul_full_head: got %h want 100", rd_data); end
        n_cmp++; if (full !== 1'b0) begin n_err++; $display("FAIL simul_full_after: got %b want 0", full); end
        rd_en = 1'b1;
        for (int i = 1; i < 16; i++) begin
            tick();
            n_cmp++; if (rd_data !== 32'h100 + i) begin n_err++; $display("FAIL simul_full_read%0d: got %h want %h", i, rd_data, 32'h100 + i); end
        end
        rd_en = 1'b0;
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL simul_full_dropped: got %b want 1", empty); end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1; wr_data = 32'hA1 + i;
            tick();
        end
        wr_en = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL midrst_empty: got %b want 1", empty); end
        n_cmp++; if (rd_data !== 32'h0) begin n_err++; $display("FAIL midrst_rd_data: got %h want 0", rd_data); end
        wr_en = 1'b1; wr_data = 32'h42;
        tick();
        wr_en = 1'b0; rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        n_cmp++; if (rd_data !== 32'h42) begin n_err++; $display("FAIL midrst_read: got %h want 42", rd_data); end
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL midrst_final_empty: got %b want 1", empty); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_wrap();
        test_simul();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
